// File: rtl/scan_display_counter_pkg.sv
// Shared seven-segment definitions for the scanning display: bit order and
// active-low glyph codes.
package disp_pkg;

  // Segment bus bit order, MSB first: {dp,g,f,e,d,c,b,a}; a low bit lights the segment.
  typedef struct packed {
    logic dp;
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Width of a counter/index that must hold values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_display_counter_if.sv
// Connector-side bundle of the scanning display: run enable in, digit select,
// segment bus and rollover pulse out.
interface scan_display_counter_if #(
  parameter int DIGITS = 4
);
  logic              start;
  logic [DIGITS-1:0] ds;
  logic [7:0]        seg;
  logic              wrap;

  modport master (output start, input ds, seg, wrap);
  modport slave  (input start, output ds, seg, wrap);
endinterface

// File: rtl/scan_display_counter_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder; codes above 9
// produce a blank glyph and the decimal point is always dark.
module bcd_to_seg
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);

  seg_t w_seg;

  always_comb begin
    w_seg = seg_t'(SEG_BLANK);
    case (i_bcd)
      4'd0:    w_seg = seg_t'(SEG_0);
      4'd1:    w_seg = seg_t'(SEG_1);
      4'd2:    w_seg = seg_t'(SEG_2);
      4'd3:    w_seg = seg_t'(SEG_3);
      4'd4:    w_seg = seg_t'(SEG_4);
      4'd5:    w_seg = seg_t'(SEG_5);
      4'd6:    w_seg = seg_t'(SEG_6);
      4'd7:    w_seg = seg_t'(SEG_7);
      4'd8:    w_seg = seg_t'(SEG_8);
      4'd9:    w_seg = seg_t'(SEG_9);
      default: w_seg = seg_t'(SEG_BLANK);
    endcase
    w_seg.dp = 1'b1;
  end

  assign o_seg = w_seg;

endmodule

// File: rtl/scan_display_counter.sv
// Multi-digit BCD counter with time-multiplexed seven-segment scan output.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module scan_display_counter
  import disp_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 2,
  parameter int TICK_DIV = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  scan_display_counter_if.slave  bus
);

  localparam int IDX_W  = idx_width(DIGITS);
  localparam int SCAN_W = idx_width(SCAN_DIV);
  localparam int TICK_W = idx_width(TICK_DIV);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DIGITS-1:0] DS_ONE    = DIGITS'(1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        r_bcd [DIGITS];
  logic [DIGITS-1:0] r_ds;
  logic [7:0]        r_seg;
  logic              r_wrap;

  logic              w_tick_last;
  logic              w_scan_last;
  logic              w_inc;
  logic [DIGITS:0]   w_carry;
  logic [3:0]        w_bcd_next [DIGITS];
  logic [3:0]        w_cur_digit;
  logic [7:0]        w_seg_dec;
  logic              w_blank;

  assign w_tick_last = (r_tick_cnt == TICK_LAST);
  assign w_scan_last = (r_scan_cnt == SCAN_LAST);
  assign w_inc       = bus.start && w_tick_last;

  // Ripple carry through the decades; carry out of the top digit is the rollover.
  assign w_carry[0] = w_inc;
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_carry[gi+1]   = w_carry[gi] && (r_bcd[gi] == 4'd9);
      assign w_bcd_next[gi]  = !w_carry[gi]        ? r_bcd[gi] :
                               (r_bcd[gi] == 4'd9) ? 4'd0      :
                                                     r_bcd[gi] + 4'd1;
    end
  endgenerate

  always_comb begin
    w_cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_digit = r_bcd[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // w_upper_zero[i]: digit i and everything above it are zero.
  logic [DIGITS:0] w_upper_zero;
  assign w_upper_zero[DIGITS] = 1'b1;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign w_upper_zero[gi] = w_upper_zero[gi+1] && (r_bcd[gi] == 4'd0);
    end
  endgenerate

  always_comb begin
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_blank = (i != 0) && w_upper_zero[i];
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  bcd_to_seg u_dec (
    .i_bcd (w_cur_digit),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        r_bcd[i] <= 4'd0;
      end
      r_wrap <= 1'b0;
    end else begin
      if (bus.start) begin
        r_tick_cnt <= w_tick_last ? '0 : r_tick_cnt + TICK_W'(1);
      end
      for (int i = 0; i < DIGITS; i++) begin
        r_bcd[i] <= w_bcd_next[i];
      end
      r_wrap <= w_carry[DIGITS];
    end
  end

  // Scan runs whether or not the counter is enabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (w_scan_last) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ds  <= '1;
      r_seg <= SEG_BLANK;
    end else begin
      r_ds  <= ~(DS_ONE << r_idx);
      r_seg <= w_blank ? SEG_BLANK : w_seg_dec;
    end
  end

  assign bus.ds   = r_ds;
  assign bus.seg  = r_seg;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_scan_display_counter.sv
// Directed bench: a default-parameter instance and a TICK_DIV=1 instance,
// checked against hand-computed digit-select and segment values.
module tb_scan_display_counter;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  scan_display_counter_if #(.DIGITS(4)) if_a ();
  scan_display_counter_if #(.DIGITS(4)) if_b ();

  scan_display_counter #(.DIGITS(4), .SCAN_DIV(2), .TICK_DIV(8)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a.slave)
  );

  scan_display_counter #(.DIGITS(4), .SCAN_DIV(2), .TICK_DIV(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b.slave)
  );

  int checks = 0;
  int errors = 0;
  int wrap_a = 0;
  int wrap_b = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] Z_HI = 8'hFF;
`else
  localparam logic [7:0] Z_HI = 8'hC0;
`endif

  typedef struct {
    logic       start;
    logic [3:0] ds;
    logic [7:0] seg;
    logic       wrap;
  } vec_t;

  vec_t vecs [9];

  always @(negedge clk) begin
    if (if_a.wrap === 1'b1) wrap_a++;
    if (if_b.wrap === 1'b1) wrap_b++;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [15:0] cnt, input int d);
    logic [3:0] v;
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] hi;
    hi = cnt >> (d * 4);
    if (d > 0 && hi == 16'h0) return 8'hFF;
`endif
    v = cnt[d*4 +: 4];
    case (v)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic run(input int which, input int n);
    if (which == 0) if_a.start = 1'b1; else if_b.start = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  // Observe one full frame with the counter paused and check every digit shown.
  task automatic check_frame(input int which, input logic [15:0] cnt, input string name);
    logic [3:0] seen;
    logic [3:0] ds;
    logic [7:0] sg;
    logic [3:0] one;
    logic [3:0] pat;
    int d;
    seen = 4'b0;
    one  = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      ds = (which == 0) ? if_a.ds  : if_b.ds;
      sg = (which == 0) ? if_a.seg : if_b.seg;
      d = -1;
      for (int i = 0; i < 4; i++) begin
        pat = ~(one << i);
        if (ds == pat) d = i;
      end
      checks++;
      if (d < 0) begin
        errors++;
        $display("FAIL %s_ds_onehot: got ds=%b expected one low bit", name, ds);
      end else begin
        seen[d] = 1'b1;
        chk($sformatf("%s_seg_d%0d", name, d), sg, exp_seg(cnt, d));
      end
    end
    chk($sformatf("%s_all_digits", name), {4'b0, seen}, 8'h0F);
    $display("frame %s dut=%0d count=%h digits_seen=%b", name, which, cnt, seen);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b1110, 8'hC0, 1'b0};
    vecs[1] = '{1'b0, 4'b1110, 8'hC0, 1'b0};
    vecs[2] = '{1'b0, 4'b1101, Z_HI,  1'b0};
    vecs[3] = '{1'b0, 4'b1101, Z_HI,  1'b0};
    vecs[4] = '{1'b0, 4'b1011, Z_HI,  1'b0};
    vecs[5] = '{1'b0, 4'b1011, Z_HI,  1'b0};
    vecs[6] = '{1'b0, 4'b0111, Z_HI,  1'b0};
    vecs[7] = '{1'b0, 4'b0111, Z_HI,  1'b0};
    vecs[8] = '{1'b0, 4'b1110, 8'hC0, 1'b0};

    if_a.start = 1'b0;
    if_b.start = 1'b0;

    // Reset held for five edges.
    repeat (5) @(posedge clk);
    #1;
    chk("rst_a_ds",   {4'b0, if_a.ds}, 8'h0F);
    chk("rst_a_seg",  if_a.seg, 8'hFF);
    chk("rst_a_wrap", {7'b0, if_a.wrap}, 8'h00);
    chk("rst_b_ds",   {4'b0, if_b.ds}, 8'h0F);
    chk("rst_b_seg",  if_b.seg, 8'hFF);

    // Release and walk the scan from the first edge.
    rst_a = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if_a.start = vecs[k].start;
      @(posedge clk);
      #1;
      chk($sformatf("scan%0d_ds", k),   {4'b0, if_a.ds}, {4'b0, vecs[k].ds});
      chk($sformatf("scan%0d_seg", k),  if_a.seg, vecs[k].seg);
      chk($sformatf("scan%0d_wrap", k), {7'b0, if_a.wrap}, {7'b0, vecs[k].wrap});
      $display("vec %0d ds=%b seg=%h wrap=%b", k, if_a.ds, if_a.seg, if_a.wrap);
    end

    // One tick period, then 72 more cycles.
    run(0, 7);
    check_frame(0, 16'h0000, "a_tick7");
    run(0, 1);
    check_frame(0, 16'h0001, "a_cnt1");
    run(0, 72);
    check_frame(0, 16'h0010, "a_cnt10");

    // Pause mid-period; the held tick count resumes where it stopped.
    run(0, 4);
    for (int f = 0; f < 5; f++) check_frame(0, 16'h0010, $sformatf("a_pause%0d", f));
    run(0, 3);
    check_frame(0, 16'h0010, "a_resume3");
    run(0, 1);
    check_frame(0, 16'h0011, "a_resume4");

    // Advance to 0123, then reset in the middle of a tick period.
    run(0, 112 * 8);
    check_frame(0, 16'h0123, "a_cnt123");
    run(0, 3);
    if_a.start = 1'b1;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ds",   {4'b0, if_a.ds}, 8'h0F);
    chk("midrst_seg",  if_a.seg, 8'hFF);
    chk("midrst_wrap", {7'b0, if_a.wrap}, 8'h00);
    rst_a = 1'b1;
    if_a.start = 1'b0;
    check_frame(0, 16'h0000, "a_after_rst");
    run(0, 7);
    check_frame(0, 16'h0000, "a_rst_tick7");
    run(0, 1);
    check_frame(0, 16'h0001, "a_rst_cnt1");

    // TICK_DIV=1 instance: 10000 running cycles in total.
    rst_b = 1'b1;
    run(1, 7);
    check_frame(1, 16'h0007, "b_cnt7");
    run(1, 9858);
    check_frame(1, 16'h9865, "b_cnt9865");
    chk("b_no_wrap_yet", wrap_b[7:0], 8'd0);
    run(1, 134);
    chk("b_before_wrap", {7'b0, if_b.wrap}, 8'h00);
    if_b.start = 1'b1;
    @(posedge clk);
    #1;
    if_b.start = 1'b0;
    chk("b_wrap_pulse", {7'b0, if_b.wrap}, 8'h01);
    @(posedge clk);
    #1;
    chk("b_wrap_drop", {7'b0, if_b.wrap}, 8'h00);
    check_frame(1, 16'h0000, "b_cnt0");
    run(1, 4);
    check_frame(1, 16'h0004, "b_cnt4");

    chk("a_wrap_count", wrap_a[7:0], 8'd0);
    chk("b_wrap_count", wrap_b[7:0], 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
